ahb_master_if: RTL and testbench
================================

# ahb_master_if

AHB master bus-interface engine. It sits directly upstream of the two-master AHB arbiter: one instance per master (MASTER_ID 0 or 1). It turns a single user burst command into hbusreq/hlock requests, waits for hgrant, then drives the address and control phases. It handles wait states, RETRY, SPLIT, ERROR and loss of grant mid-burst, and returns per-beat read data and a completion pulse.

## Interface
- MASTER_ID, 0: bus index of this master; selects which arbiter hgrant/hbusreq bit is wired here.
- AW, 32: address width.
- DW, 32: data width; hsize fixed at word (3'b010), address step 4.
- MAX_LEN, 16: maximum beats for INCR commands.
- clk  in  1  bus clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  AW  start address, word aligned.
- cmd_write  in  1  1 = write.
- cmd_burst  in  3  hburst_t encoding.
- cmd_len  in  5  beat count for INCR (1..MAX_LEN); ignored otherwise.
- cmd_lock  in  1  request locked transfer.
- wdata  in  DW  write data for beat wbeat; must be valid in every write data-phase cycle.
- wbeat  out  5  beat index of the current data phase.
- rdata  out  DW  registered hrdata.
- rdata_valid  out  1  one-cycle pulse per OKAY read beat; rbeat gives its index.
- rbeat  out  5  beat index for rdata.
- done  out  1  one-cycle pulse at command end.
- err  out  1  coincident with done if ERROR terminated the burst.
- hbusreq, hlock  out  1  to arbiter.
- hgrant  in  1  this master's grant bit.
- hready  in  1  bus ready.
- hresp  in  2  hresp_t.
- htrans  out  2.
- haddr  out  AW.
- hwrite  out  1.
- hburst  out  3.
- hsize  out  3.
- hwdata  out  DW.
- hrdata  in  DW.

## Operation
- States: IDLE, REQ, XFER, DRAIN, RESP2.
- IDLE: cmd_ready=1. On cmd_valid, latch the command and go to REQ. beats = calc_beat(cmd_burst); INCR uses cmd_len; SINGLE uses 1.
- REQ: hbusreq=1, hlock=cmd_lock, htrans=IDLE. Ownership is taken at an edge with hgrant&hready; go to XFER.
- XFER: drive haddr = current address. htrans is NONSEQ on the first beat after every (re)acquisition, otherwise SEQ. The address advances at each hready edge.
  - Next address is +4.
  - WRAP4/8/16 wrap within a 16/32/64-byte boundary.
  - After the last address is accepted, go to DRAIN with htrans=IDLE.
- hbusreq drops in the cycle the last address is driven. hlock holds until the last address is accepted.
- Grant loss: hgrant=0 at an hready edge mid-burst ends address issue. The outstanding data phase completes, then the block returns to REQ.
  - It resumes at the next beat's address with NONSEQ.
  - hburst is forced to INCR for the remainder.
- Data phase: a one-entry pipeline register holds the beat index, write flag and valid.
  - hwdata = wdata combinationally, selected by wbeat.
  - A read OKAY beat produces rdata_valid next cycle.
- RETRY/SPLIT: first response cycle (hready=0, hresp≠OKAY) forces htrans=IDLE and cancels the pipelined address. In RESP2 (second cycle) the beat counter rewinds to the failed beat, then the block goes to REQ and re-issues that beat with NONSEQ.
- ERROR: same two-cycle cancel. After RESP2, pulse done+err and go to IDLE. Remaining beats are dropped.
- INCR 1 KB boundary crossing is not checked; the command issuer guarantees it never occurs.

## Timing
- Reset values: state IDLE, cmd_ready=1, hbusreq=0, hlock=0, htrans=IDLE, haddr=0, hwrite=0, hburst=SINGLE, hsize=3'b010, wbeat=0, rbeat=0, rdata_valid=0, done=0, err=0.
- Command accept to hbusreq: 1 cycle.
- Grant edge to NONSEQ on bus: 0 cycles. htrans is valid in the cycle after the hgrant&hready edge.
- done pulses 1 cycle after the final OKAY data phase (hready=1).
- Simultaneous events:
  - Grant loss together with RETRY: RETRY wins, since a rewind covers both.
  - A RETRY/SPLIT response in the final data phase still rewinds.
- Reset mid-burst aborts immediately: outputs take reset values, and no done pulse is issued.

## Structure
- ahb_pkg is extended with:
  - the htrans_t, hburst_t and hresp_t enums (already present);
  - calc_beat (already present);
  - a new mst_state_t enum;
  - a next_addr(addr, burst) function implementing the incr/wrap rules.
- One natural sub-module, ahb_addr_gen: holds the current address and beat counter, and supports load, advance and rewind.

## Test plan
- SINGLE write 0x100, data 0xA5A5_0001, immediate grant -> NONSEQ at 0x100, hwdata matches, done 1 cycle after OKAY, hbusreq dropped.
- INCR4 read 0x200, hready low 2 cycles on beat 1 -> addresses 0x200/204/208/20C, NONSEQ,SEQ,SEQ,SEQ, 4 rdata_valid pulses with rbeat 0..3.
- WRAP8 read 0x1C -> address sequence 0x1C,0x00,0x04,...,0x18.
- INCR4 write 0x300, RETRY on beat 2 -> htrans IDLE during the response, re-issue NONSEQ at 0x308 with wbeat=2, done after beat 3.
- INCR8 read 0x400, hgrant removed after beat 3 address -> data phase 3 completes, re-request, NONSEQ at 0x410 with hburst=INCR, 8 total rdata_valid.
- ERROR on beat 1 of INCR4 -> done and err pulse together, no further NONSEQ. Separately, rst asserted mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB enums, master FSM states and burst address helpers
package ahb_pkg;
  typedef enum logic [1:0] {HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ} htrans_t;
  typedef enum logic [2:0] {HB_SINGLE, HB_INCR, HB_WRAP4, HB_INCR4, HB_WRAP8, HB_INCR8, HB_WRAP16, HB_INCR16} hburst_t;
  typedef enum logic [1:0] {HR_OKAY, HR_ERROR, HR_RETRY, HR_SPLIT} hresp_t;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_DRAIN, S_RESP2} mst_state_t;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  function automatic logic [4:0] calc_beat(input hburst_t b);
    return b == HB_SINGLE ? 5'd1 :
           (b == HB_WRAP4 || b == HB_INCR4) ? 5'd4 :
           (b == HB_WRAP8 || b == HB_INCR8) ? 5'd8 :
           (b == HB_WRAP16 || b == HB_INCR16) ? 5'd16 : 5'd0;
  endfunction
  // Bursts never cross 1 KB, so only the low 10 address bits can change.
  function automatic logic [9:0] next_addr(input logic [9:0] a, input hburst_t b);
    logic [9:0] m;
    m = b == HB_WRAP4 ? 10'h00f : b == HB_WRAP8 ? 10'h01f : b == HB_WRAP16 ? 10'h03f : 10'h3ff;
    return (a & ~m) | ((a + 10'd4) & m);
  endfunction
endpackage

// File: rtl/ahb_addr_gen.sv
// ahb_addr_gen: current burst address and beat counter with load, advance and one-beat rewind
module ahb_addr_gen
  import ahb_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  input  logic          rew,
  input  logic [AW-1:0] start,
  input  hburst_t       burst,
  output logic [AW-1:0] addr,
  output logic [AW-1:0] nxt,
  output logic [4:0]    beat
);
  logic [AW-1:0] prev;
  assign nxt = {addr[AW-1:10], next_addr(addr[9:0], burst)};
  // prev is the address of the beat in its data phase, the only one a rewind can target
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      prev <= '0;
      beat <= '0;
    end else if (load) begin
      addr <= start;
      prev <= start;
      beat <= '0;
    end else if (rew) begin
      addr <= prev;
      beat <= beat - 5'd1;
    end else if (adv) begin
      prev <= addr;
      addr <= nxt;
      beat <= beat + 5'd1;
    end
endmodule

// File: rtl/ahb_master_if.sv
// ahb_master_if: turns one burst command into AHB request, address and data phases
module ahb_master_if
  import ahb_pkg::*;
#(
  parameter int MASTER_ID = 0,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_LEN   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic          cmd_write,
  input  logic [2:0]    cmd_burst,
  input  logic [4:0]    cmd_len,
  input  logic          cmd_lock,
  input  logic [DW-1:0] wdata,
  output logic [4:0]    wbeat,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic [4:0]    rbeat,
  output logic          done,
  output logic          err,
  output logic          hbusreq,
  output logic          hlock,
  input  logic          hgrant,
  input  logic          hready,
  input  logic [1:0]    hresp,
  output logic [1:0]    htrans,
  output logic [AW-1:0] haddr,
  output logic          hwrite,
  output logic [2:0]    hburst,
  output logic [2:0]    hsize,
  output logic [DW-1:0] hwdata,
  input  logic [DW-1:0] hrdata
);
  mst_state_t state;
  hburst_t burst;
  logic [4:0] len, beat, dp_beat;
  logic [AW-1:0] cur, nxt;
  logic lock, wr, dp_valid, dp_write, rsp_err, acc, rew, last;
  if (MASTER_ID > 1) begin : g_bad_id
    $error("ahb_master_if: MASTER_ID must be 0 or 1");
  end
  assign cmd_ready = state == S_IDLE;
  assign acc = state == S_XFER && hready;
  assign rew = state == S_RESP2 && hready;
  assign last = beat == len - 5'd1;
  assign hsize = HSIZE_WORD;
  assign hwdata = wdata;
  assign wbeat = dp_beat;
  ahb_addr_gen #(.AW(AW)) u_addr (
    .clk(clk), .rst(rst), .load(cmd_ready && cmd_valid), .adv(acc), .rew(rew),
    .start(cmd_addr), .burst(burst), .addr(cur), .nxt(nxt), .beat(beat)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      burst <= HB_SINGLE;
      len <= '0;
      lock <= 1'b0;
      wr <= 1'b0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_beat <= '0;
      rsp_err <= 1'b0;
      hbusreq <= 1'b0;
      hlock <= 1'b0;
      htrans <= HT_IDLE;
      haddr <= '0;
      hwrite <= 1'b0;
      hburst <= HB_SINGLE;
      rdata <= '0;
      rdata_valid <= 1'b0;
      rbeat <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      if ((state == S_XFER || state == S_DRAIN) && hready && hresp == HR_OKAY && dp_valid && !dp_write) begin
        rdata_valid <= 1'b1;
        rdata <= hrdata;
        rbeat <= dp_beat;
      end
      case (state)
        S_IDLE: if (cmd_valid) begin
          state <= S_REQ;
          burst <= hburst_t'(cmd_burst);
          len <= hburst_t'(cmd_burst) == HB_INCR ? (cmd_len > 5'(MAX_LEN) ? 5'(MAX_LEN) : cmd_len)
                                                 : calc_beat(hburst_t'(cmd_burst));
          lock <= cmd_lock;
          wr <= cmd_write;
          hbusreq <= 1'b1;
          hlock <= cmd_lock;
        end
        // a resumed burst (after grant loss or retry) is no longer a fixed-length burst
        S_REQ: if (hgrant && hready) begin
          state <= S_XFER;
          htrans <= HT_NONSEQ;
          haddr <= cur;
          hwrite <= wr;
          hburst <= beat == 5'd0 ? burst : HB_INCR;
          hbusreq <= !last;
        end
        S_XFER: if (hready) begin
          dp_valid <= 1'b1;
          dp_beat <= beat;
          dp_write <= wr;
          if (last || !hgrant) begin
            state <= S_DRAIN;
            htrans <= HT_IDLE;
          end else begin
            htrans <= HT_SEQ;
            haddr <= nxt;
            hbusreq <= beat + 5'd2 != len;
          end
          if (last) begin
            hlock <= 1'b0;
            hbusreq <= 1'b0;
          end
        end else if (hresp != HR_OKAY && dp_valid) begin
          state <= S_RESP2;
          htrans <= HT_IDLE;
          rsp_err <= hresp == HR_ERROR;
        end
        S_DRAIN: if (hready) begin
          dp_valid <= 1'b0;
          state <= beat == len ? S_IDLE : S_REQ;
          done <= beat == len;
          hbusreq <= beat != len;
        end else if (hresp != HR_OKAY) begin
          state <= S_RESP2;
          rsp_err <= hresp == HR_ERROR;
        end
        S_RESP2: if (hready) begin
          dp_valid <= 1'b0;
          state <= rsp_err ? S_IDLE : S_REQ;
          hbusreq <= !rsp_err;
          hlock <= !rsp_err && lock;
          done <= rsp_err;
          err <= rsp_err;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_ahb_master_if.sv
// tb_ahb_master_if: random commands against a random slave/arbiter, checked by a transaction-level bus model
module tb_ahb_master_if;
  import ahb_pkg::*;
  logic clk = 1'b0, rst;
  logic cmd_valid, cmd_ready, cmd_write, cmd_lock;
  logic [31:0] cmd_addr, wdata, rdata, haddr, hwdata, hrdata;
  logic [2:0] cmd_burst, hburst, hsize;
  logic [4:0] cmd_len, wbeat, rbeat;
  logic rdata_valid, done, err, hbusreq, hlock, hgrant, hready, hwrite;
  logic [1:0] hresp, htrans;

  ahb_master_if #(.MASTER_ID(0), .AW(32), .DW(32), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_lock(cmd_lock),
    .wdata(wdata), .wbeat(wbeat), .rdata(rdata), .rdata_valid(rdata_valid), .rbeat(rbeat),
    .done(done), .err(err), .hbusreq(hbusreq), .hlock(hlock), .hgrant(hgrant), .hready(hready),
    .hresp(hresp), .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hburst(hburst),
    .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Model of the command in flight: expected beat addresses and bus/data-phase bookkeeping
  logic [31:0] ea[16];
  logic [31:0] wbase, exp_rd;
  logic [4:0] exp_rb;
  logic [2:0] c_burst;
  logic [1:0] dpresp;
  logic c_write, c_lock;
  int len, nxt, need, dpb, dpwait;
  bit active, pend, owner, dpv, dpstage, seen_act;
  bit exp_rv, exp_done, exp_err, exp_idle, exp_req;

  task automatic start_model();
    int sz;
    bit wrap;
    c_write = cmd_write;
    c_lock = cmd_lock;
    c_burst = cmd_burst;
    case (cmd_burst)
      3'd0: len = 1;
      3'd1: len = int'(cmd_len);
      3'd2, 3'd3: len = 4;
      3'd4, 3'd5: len = 8;
      default: len = 16;
    endcase
    wrap = cmd_burst inside {3'd2, 3'd4, 3'd6};
    sz = 4 * len;
    for (int i = 0; i < len; i++)
      ea[i] = wrap ? ((cmd_addr & ~32'(sz - 1)) | ((cmd_addr + 32'(4 * i)) & 32'(sz - 1)))
                   : cmd_addr + 32'(4 * i);
    active = 1;
    nxt = 0;
    need = 1;
    exp_req = 1;
  endtask

  task automatic cycle();
    bit act_tr;
    int r;
    @(negedge clk);
    chk("done", done, exp_done);
    chk("err", err, exp_err);
    chk("rdata_valid", rdata_valid, exp_rv);
    if (exp_rv) begin
      chk("rbeat", rbeat, exp_rb);
      chk("rdata", rdata, exp_rd);
    end
    if (exp_done) chk("cmd_ready_at_done", cmd_ready, 1);
    if (exp_idle) chk("htrans_idle_resp2", htrans, HT_IDLE);
    if (exp_req) begin
      chk("hbusreq_after_accept", hbusreq, 1);
      chk("hlock_after_accept", hlock, c_lock);
    end
    {exp_rv, exp_done, exp_err, exp_idle, exp_req} = '0;
    hgrant = $urandom_range(0, 9) != 0;
    hrdata = $urandom;
    wdata = wbase ^ 32'(wbeat);
    hready = 1'b1;
    hresp = HR_OKAY;
    if (dpv && dpwait > 0) hready = 1'b0;
    else if (dpv && dpresp != HR_OKAY) begin
      hresp = dpresp;
      hready = dpstage;
    end
    cmd_valid = pend && cmd_ready;
    #1;
    act_tr = htrans == HT_NONSEQ || htrans == HT_SEQ;
    seen_act = act_tr;
    if (act_tr) begin
      chk("owner", owner, 1);
      chk("beat_in_range", nxt < len, 1);
      if (nxt < len) chk("haddr", haddr, ea[nxt]);
      chk("htrans", htrans, need != 0 ? HT_NONSEQ : HT_SEQ);
      chk("hwrite", hwrite, c_write);
      if (need == 1) chk("hburst_first", hburst, c_burst);
      if (need == 2) chk("hburst_resume", hburst, HB_INCR);
      if (nxt == len - 1) chk("hbusreq_last", hbusreq, 0);
    end
    if (dpv && c_write && dpwait == 0 && hready && hresp == HR_OKAY) begin
      chk("hwdata", hwdata, wbase ^ 32'(dpb));
      chk("wbeat", wbeat, dpb);
    end
    if (dpv) begin
      if (dpwait > 0) dpwait--;
      else if (dpresp == HR_OKAY) begin
        dpv = 0;
        if (!c_write) begin
          exp_rv = 1;
          exp_rb = 5'(dpb);
          exp_rd = hrdata;
        end
        if (dpb == len - 1) begin
          exp_done = 1;
          active = 0;
        end
      end else if (!dpstage) begin
        dpstage = 1;
        exp_idle = 1;
      end else begin
        dpv = 0;
        if (dpresp == HR_ERROR) begin
          exp_done = 1;
          exp_err = 1;
          active = 0;
        end else begin
          nxt = dpb;
          need = 3;
        end
      end
    end
    if (act_tr && hready) begin
      dpv = 1;
      dpb = nxt;
      dpstage = 0;
      dpwait = $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0;
      r = $urandom_range(0, 99);
      dpresp = r < 4 ? HR_ERROR : r < 9 ? HR_RETRY : r < 13 ? HR_SPLIT : HR_OKAY;
      need = (nxt < len - 1 && !hgrant) ? 2 : 0;
      nxt++;
    end
    if (hready) owner = hgrant;
    if (cmd_valid) begin
      pend = 0;
      start_model();
    end
  endtask

  task automatic new_cmd();
    cmd_burst = 3'($urandom_range(0, 7));
    cmd_len = 5'($urandom_range(1, 16));
    cmd_addr = ($urandom & 32'hffff_fc00) | (32'($urandom_range(0, 239)) << 2);
    cmd_write = 1'($urandom);
    cmd_lock = 1'($urandom);
    wbase = $urandom;
    pend = 1;
  endtask

  initial begin
    int t;
    bit timed_out;
    rst = 1'b1;
    {cmd_valid, cmd_write, cmd_lock, hgrant, hready} = '0;
    {cmd_addr, wdata, hrdata, cmd_burst, cmd_len, hresp, wbase} = '0;
    {active, pend, owner, dpv, dpstage} = '0;
    {exp_rv, exp_done, exp_err, exp_idle, exp_req} = '0;
    len = 0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_hbusreq", hbusreq, 0);
    chk("rst_hlock", hlock, 0);
    chk("rst_htrans", htrans, HT_IDLE);
    chk("rst_haddr", haddr, 0);
    chk("rst_hwrite", hwrite, 0);
    chk("rst_hburst", hburst, HB_SINGLE);
    chk("rst_hsize", hsize, 3'b010);
    chk("rst_wbeat", wbeat, 0);
    chk("rst_rbeat", rbeat, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_done_err", {done, err}, 0);
    rst = 1'b0;
    timed_out = 0;
    for (int c = 0; c < 80 && !timed_out; c++) begin
      new_cmd();
      t = 0;
      do begin
        cycle();
        t++;
      end while ((pend || active) && t < 600);
      if (pend || active) begin
        chk("command_timeout", 0, 1);
        timed_out = 1;
      end
    end
    cycle();
    if (!timed_out) begin
      new_cmd();
      t = 0;
      do begin
        cycle();
        t++;
      end while (!seen_act && t < 50);
      chk("reset_test_reached_bus", seen_act, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_htrans", htrans, HT_IDLE);
      chk("mid_rst_hbusreq", hbusreq, 0);
      chk("mid_rst_hlock", hlock, 0);
      chk("mid_rst_haddr", haddr, 0);
      chk("mid_rst_hburst", hburst, HB_SINGLE);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      chk("mid_rst_wbeat", wbeat, 0);
      chk("mid_rst_pulses", {rdata_valid, done, err}, 0);
      {active, pend, owner, dpv, dpstage} = '0;
      {exp_rv, exp_done, exp_err, exp_idle, exp_req} = '0;
      cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
